clock_time_core: RTL and testbench

Free-running 24-hour timekeeping core, directly downstream of the time-setting stage. Divides clk into a 1 Hz tick and keeps BCD hours:minutes:seconds. Pauses while the user is setting time. Loads the user-set digits on the setter's acknowledge strobe and drives the display stage.

---
 rtl/clock_time_core.sv | 153 +++++++++++++++
 tb/tb_clock_time_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_core.sv
// 24-hour BCD timekeeping core: 1 Hz prescaler, hh:mm:ss counter, validated load, hold freeze.
// Optional alarm comparator enabled by defining ALARM_MATCH_EN.
module clock_time_core #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       load_stb,
  input  logic [1:0] ld_hours_left,
  input  logic [3:0] ld_hours_right,
  input  logic [2:0] ld_minutes_left,
  input  logic [3:0] ld_minutes_right,
`ifdef ALARM_MATCH_EN
  input  logic       alarm_arm,
  input  logic [1:0] al_hours_left,
  input  logic [3:0] al_hours_right,
  input  logic [2:0] al_minutes_left,
  input  logic [3:0] al_minutes_right,
  output logic       alarm_hit,
`endif
  output logic [1:0] hours_left,
  output logic [3:0] hours_right,
  output logic [2:0] minutes_left,
  output logic [3:0] minutes_right,
  output logic [2:0] seconds_left,
  output logic [3:0] seconds_right,
  output logic       tick_1hz,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          wrap;
  logic          ld_valid;

  logic [1:0] hl_n;
  logic [3:0] hr_n;
  logic [2:0] ml_n;
  logic [3:0] mr_n;
  logic [2:0] sl_n;
  logic [3:0] sr_n;

  assign wrap = (presc == LAST);

  // Reject out-of-range digits and hours above 23
  assign ld_valid = (ld_hours_left <= 2'd2) && (ld_hours_right <= 4'd9) &&
                    !((ld_hours_left == 2'd2) && (ld_hours_right > 4'd3)) &&
                    (ld_minutes_left <= 3'd5) && (ld_minutes_right <= 4'd9);

  // One-second BCD increment with ripple carries, 23:59:59 wraps to 00:00:00
  always_comb begin
    hl_n = hours_left;
    hr_n = hours_right;
    ml_n = minutes_left;
    mr_n = minutes_right;
    sl_n = seconds_left;
    sr_n = seconds_right;
    if (seconds_right != 4'd9) begin
      sr_n = seconds_right + 4'd1;
    end else begin
      sr_n = 4'd0;
      if (seconds_left != 3'd5) begin
        sl_n = seconds_left + 3'd1;
      end else begin
        sl_n = 3'd0;
        if (minutes_right != 4'd9) begin
          mr_n = minutes_right + 4'd1;
        end else begin
          mr_n = 4'd0;
          if (minutes_left != 3'd5) begin
            ml_n = minutes_left + 3'd1;
          end else begin
            ml_n = 3'd0;
            if ((hours_left == 2'd2) && (hours_right == 4'd3)) begin
              hl_n = 2'd0;
              hr_n = 4'd0;
            end else if (hours_right == 4'd9) begin
              hr_n = 4'd0;
              hl_n = hours_left + 2'd1;
            end else begin
              hr_n = hours_right + 4'd1;
            end
          end
        end
      end
    end
  end

  // Priority: load strobe, then hold, then prescaler advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc         <= '0;
      hours_left    <= '0;
      hours_right   <= '0;
      minutes_left  <= '0;
      minutes_right <= '0;
      seconds_left  <= '0;
      seconds_right <= '0;
      tick_1hz      <= 1'b0;
      load_err      <= 1'b0;
    end else if (load_stb) begin
      tick_1hz <= 1'b0;
      if (ld_valid) begin
        presc         <= '0;
        hours_left    <= ld_hours_left;
        hours_right   <= ld_hours_right;
        minutes_left  <= ld_minutes_left;
        minutes_right <= ld_minutes_right;
        seconds_left  <= '0;
        seconds_right <= '0;
        load_err      <= 1'b0;
      end else begin
        load_err <= 1'b1;
      end
    end else if (hold) begin
      presc    <= '0;
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
    end else if (wrap) begin
      presc         <= '0;
      hours_left    <= hl_n;
      hours_right   <= hr_n;
      minutes_left  <= ml_n;
      minutes_right <= mr_n;
      seconds_left  <= sl_n;
      seconds_right <= sr_n;
      tick_1hz      <= 1'b1;
      load_err      <= 1'b0;
    end else begin
      presc    <= presc + PW'(1);
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
    end
  end

`ifdef ALARM_MATCH_EN
  // Alarm fires only on a counting advance into second 00, never on a load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= alarm_arm && !load_stb && !hold && wrap &&
                   (sl_n == 3'd0) && (sr_n == 4'd0) &&
                   (hl_n == al_hours_left) && (hr_n == al_hours_right) &&
                   (ml_n == al_minutes_left) && (mr_n == al_minutes_right);
    end
  end
`endif

endmodule

// File: tb/tb_clock_time_core.sv
// Directed self-checking bench for clock_time_core with TICK_DIV=4.
module tb_clock_time_core;

  localparam int unsigned TD = 4;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       load_stb;
  logic [1:0] ld_hours_left;
  logic [3:0] ld_hours_right;
  logic [2:0] ld_minutes_left;
  logic [3:0] ld_minutes_right;
  logic [1:0] hours_left;
  logic [3:0] hours_right;
  logic [2:0] minutes_left;
  logic [3:0] minutes_right;
  logic [2:0] seconds_left;
  logic [3:0] seconds_right;
  logic       tick_1hz;
  logic       load_err;
`ifdef ALARM_MATCH_EN
  logic       alarm_arm;
  logic [1:0] al_hours_left;
  logic [3:0] al_hours_right;
  logic [2:0] al_minutes_left;
  logic [3:0] al_minutes_right;
  logic       alarm_hit;
`endif

  int checks = 0;
  int errors = 0;

  clock_time_core #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .hold(hold), .load_stb(load_stb),
    .ld_hours_left(ld_hours_left), .ld_hours_right(ld_hours_right),
    .ld_minutes_left(ld_minutes_left), .ld_minutes_right(ld_minutes_right),
`ifdef ALARM_MATCH_EN
    .alarm_arm(alarm_arm), .al_hours_left(al_hours_left), .al_hours_right(al_hours_right),
    .al_minutes_left(al_minutes_left), .al_minutes_right(al_minutes_right),
    .alarm_hit(alarm_hit),
`endif
    .hours_left(hours_left), .hours_right(hours_right),
    .minutes_left(minutes_left), .minutes_right(minutes_right),
    .seconds_left(seconds_left), .seconds_right(seconds_right),
    .tick_1hz(tick_1hz), .load_err(load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] hl;
    logic [3:0] hr;
    logic [2:0] ml;
    logic [3:0] mr;
    logic       err;
    int         eh;
    int         em;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [19:0] mk(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [19:0] now_t();
    return {hours_left, hours_right, minutes_left, minutes_right, seconds_left, seconds_right};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_load(input int h, input int m);
    ld_hours_left    = 2'(h / 10);
    ld_hours_right   = 4'(h % 10);
    ld_minutes_left  = 3'(m / 10);
    ld_minutes_right = 4'(m % 10);
    load_stb = 1'b1;
    step();
    load_stb = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd2, 4'd3, 3'd5, 4'd9, 1'b0, 23, 59};
    vecs[1] = '{2'd2, 4'd4, 3'd0, 4'd0, 1'b1, 23, 59};
    vecs[2] = '{2'd1, 4'd9, 3'd6, 4'd0, 1'b1, 23, 59};
    vecs[3] = '{2'd0, 4'd9, 3'd5, 4'd9, 1'b0,  9, 59};
    vecs[4] = '{2'd3, 4'd0, 3'd0, 4'd0, 1'b1,  9, 59};
    vecs[5] = '{2'd1, 4'd10, 3'd0, 4'd0, 1'b1, 9, 59};
    vecs[6] = '{2'd0, 4'd5, 3'd5, 4'd10, 1'b1, 9, 59};
    vecs[7] = '{2'd2, 4'd3, 3'd5, 4'd9, 1'b0, 23, 59};

    rst = 1'b0;
    hold = 1'b0;
    load_stb = 1'b0;
    ld_hours_left = '0;
    ld_hours_right = '0;
    ld_minutes_left = '0;
    ld_minutes_right = '0;
`ifdef ALARM_MATCH_EN
    alarm_arm = 1'b1;
    al_hours_left = 2'd0;
    al_hours_right = 4'd0;
    al_minutes_left = 3'd0;
    al_minutes_right = 4'd1;
`endif
    #3;
    chk("reset_time", 32'(now_t()), 32'(mk(0, 0, 0)));
    chk("reset_tick", 32'(tick_1hz), 32'd0);
    chk("reset_err", 32'(load_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Free run: tick every TD cycles, 10 seconds in 40 cycles
    for (int i = 0; i < 40; i++) begin
      step();
      chk("run_tick", 32'(tick_1hz), 32'(((i + 1) % TD) == 0));
    end
    chk("run_10s", 32'(now_t()), 32'(mk(0, 0, 10)));

    // Load table under hold: loads still apply, invalid ones pulse load_err
    hold = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ld_hours_left    = vecs[v].hl;
      ld_hours_right   = vecs[v].hr;
      ld_minutes_left  = vecs[v].ml;
      ld_minutes_right = vecs[v].mr;
      load_stb = 1'b1;
      step();
      load_stb = 1'b0;
      chk($sformatf("load_err_%0d", v), 32'(load_err), 32'(vecs[v].err));
      chk($sformatf("load_time_%0d", v), 32'(now_t()), 32'(mk(vecs[v].eh, vecs[v].em, 0)));
      step();
      chk($sformatf("err_clear_%0d", v), 32'(load_err), 32'd0);
      chk($sformatf("hold_time_%0d", v), 32'(now_t()), 32'(mk(vecs[v].eh, vecs[v].em, 0)));
    end

    // Midnight wrap from 23:59:00 after 60 ticks
    hold = 1'b0;
    steps(60 * TD - 1);
    chk("pre_midnight", 32'(now_t()), 32'(mk(23, 59, 59)));
    chk("pre_midnight_tick", 32'(tick_1hz), 32'd0);
    step();
    chk("midnight", 32'(now_t()), 32'(mk(0, 0, 0)));
    chk("midnight_tick", 32'(tick_1hz), 32'd1);

    // Hour-tens carry 09:59:59 -> 10:00:00
    do_load(9, 59);
    chk("load_0959", 32'(now_t()), 32'(mk(9, 59, 0)));
    steps(59 * TD);
    chk("t_095959", 32'(now_t()), 32'(mk(9, 59, 59)));
    steps(TD);
    chk("t_100000", 32'(now_t()), 32'(mk(10, 0, 0)));

    // Hold mid-count freezes everything; release restarts a full period
    steps(6);
    chk("pre_hold", 32'(now_t()), 32'(mk(10, 0, 1)));
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_tick", 32'(tick_1hz), 32'd0);
      chk("hold_frozen", 32'(now_t()), 32'(mk(10, 0, 1)));
    end
    hold = 1'b0;
    for (int i = 1; i <= int'(TD); i++) begin
      step();
      chk("release_tick", 32'(tick_1hz), 32'(i == int'(TD)));
    end
    chk("release_time", 32'(now_t()), 32'(mk(10, 0, 2)));

    // Load collides with a prescaler wrap: load wins
    steps(TD - 1);
    do_load(12, 34);
    chk("wrap_load_time", 32'(now_t()), 32'(mk(12, 34, 0)));
    chk("wrap_load_tick", 32'(tick_1hz), 32'd0);
    for (int i = 1; i <= int'(TD); i++) begin
      step();
      chk("post_load_tick", 32'(tick_1hz), 32'(i == int'(TD)));
    end
    chk("post_load_time", 32'(now_t()), 32'(mk(12, 34, 1)));

    // Async reset mid-count at 12:34:56
    steps(55 * TD);
    chk("t_123456", 32'(now_t()), 32'(mk(12, 34, 56)));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_time", 32'(now_t()), 32'(mk(0, 0, 0)));
    chk("async_rst_tick", 32'(tick_1hz), 32'd0);
    #1 rst = 1'b1;
    for (int i = 1; i <= 60 * int'(TD); i++) begin
      step();
      if (i == int'(TD)) chk("resume_1s", 32'(now_t()), 32'(mk(0, 0, 1)));
`ifdef ALARM_MATCH_EN
      chk("alarm_hit", 32'(alarm_hit), 32'(i == 60 * int'(TD)));
`endif
    end
    chk("resume_1min", 32'(now_t()), 32'(mk(0, 1, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
